// File: rtl/vdp_pkg.sv
// ----------------------------------------------------------------------------
// vdp_pkg
//   Shared constants and helpers for the VDP CPU I/O front end.
//   - Port offsets relative to the I/O base (data, control, indirect).
//   - Status register bit positions and the interrupt-enable bit in R1.
//   - decode_port(): maps a CPU I/O address onto one of the VDP ports.
// ----------------------------------------------------------------------------
package vdp_pkg;

  localparam logic [7:0] OFS_DATA = 8'd0;
  localparam logic [7:0] OFS_CTRL = 8'd1;
  localparam logic [7:0] OFS_IND  = 8'd3;

  localparam int ST_F_BIT  = 7;
  localparam int ST_5S_BIT = 6;
  localparam int ST_C_BIT  = 5;
  localparam int R1_IE_BIT = 5;

  typedef enum logic [1:0] {
    PORT_NONE,
    PORT_DATA,
    PORT_CTRL,
    PORT_IND
  } port_e;

  // The indirect port only decodes when the feature is built in; otherwise
  // that address is left unmapped like any other.
  function automatic port_e decode_port(input logic [7:0] addr,
                                        input logic [7:0] base,
                                        input logic       ind_en);
    if (addr == base + OFS_DATA) return PORT_DATA;
    if (addr == base + OFS_CTRL) return PORT_CTRL;
    if (ind_en && (addr == base + OFS_IND)) return PORT_IND;
    return PORT_NONE;
  endfunction

endpackage

// File: rtl/vdp_status_reg.sv
// ----------------------------------------------------------------------------
// vdp_status_reg
//   VDP status register: frame (F), fifth-sprite (5S), collision (C) flags and
//   the 5-bit fifth-sprite number, plus the registered active-low interrupt.
//   Ports:
//     clk, reset      clock, synchronous active-high reset
//     f_set, c_set    one-cycle set pulses for F and C
//     s5_set, s5_num  fifth-sprite pulse and number (number captured on pulse)
//     rd_clr          status read accepted this cycle: clear F/5S/C next edge
//     ie              interrupt enable (R1 bit 5)
//     status          {F, 5S, C, num}
//     n_int           active-low IRQ, registered: !(F & ie) one edge late
// ----------------------------------------------------------------------------
module vdp_status_reg
  import vdp_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       f_set,
  input  logic       c_set,
  input  logic       s5_set,
  input  logic [4:0] s5_num,
  input  logic       rd_clr,
  input  logic       ie,
  output logic [7:0] status,
  output logic       n_int
);

  logic       f_q;
  logic       s5_q;
  logic       c_q;
  logic [4:0] num_q;

  // NOTE: state is written with non-blocking assignments only; the clear and
  // set below are both scheduled, and the later one in program order wins,
  // which is exactly what makes a coincident set pulse survive a status read.
  always_ff @(posedge clk) begin
    if (reset) begin
      f_q   <= 1'b0;
      s5_q  <= 1'b0;
      c_q   <= 1'b0;
      num_q <= '0;
      n_int <= 1'b1;
    end else begin
      if (rd_clr) begin
        f_q  <= 1'b0;
        s5_q <= 1'b0;
        c_q  <= 1'b0;
      end
      if (f_set)  f_q  <= 1'b1;
      if (c_set)  c_q  <= 1'b1;
      if (s5_set) begin
        s5_q  <= 1'b1;
        num_q <= s5_num;
      end
      // Built from the registered flag, so the IRQ follows F by one edge.
      n_int <= !(f_q && ie);
    end
  end

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    status            = '0;
    status[ST_F_BIT]  = f_q;
    status[ST_5S_BIT] = s5_q;
    status[ST_C_BIT]  = c_q;
    status[4:0]       = num_q;
  end

endmodule

// File: rtl/vdp_cpu_port.sv
// ----------------------------------------------------------------------------
// vdp_cpu_port
//   TMS9918/V99x8-style CPU I/O front end for the VDP. Decodes the data and
//   control ports, keeps the two-byte address/register latch, the
//   auto-incrementing VRAM address, the read-ahead buffer, the control
//   register file and the status register / interrupt. VRAM accesses go out
//   over a one-outstanding req/ack handshake.
//
//   Optional feature macro: VDP_INDIRECT_EN
//     defined   : register write to index IND_REG loads the indirect pointer
//                 (ptr = first_byte[5:0], noinc = first_byte[7]); writes to
//                 IO_BASE+3 store into r[ptr] and advance ptr unless noinc.
//     undefined : IO_BASE+3 is unmapped, IND_REG is an ordinary index.
//
//   Parameters: ADDR_W (VRAM address width), NUM_REGS (>= 2, stored control
//   registers), IO_BASE (data port address), IND_REG (indirect pointer index).
//
//   Ports:
//     clk, reset            clock, synchronous active-high reset
//     io_addr/io_wdata      CPU I/O address low byte / write data
//     io_wr_stb/io_rd_stb   one-cycle qualified strobes (write wins if both)
//     io_rdata              combinational read data for the addressed port
//     vram_req/we/addr/wdata  request to VRAM controller, held until ack
//     vram_ack/vram_rdata   one-cycle ack, read data valid with it
//     stat_*_set/5s_num     status event pulses from the renderer
//     regs_flat             register file, r[i] at [8*i +: 8]
//     n_int                 active-low interrupt
//     busy                  VRAM op outstanding
//     overrun               sticky: data-port access dropped while busy
// ----------------------------------------------------------------------------
module vdp_cpu_port
  import vdp_pkg::*;
#(
  parameter int         ADDR_W   = 14,
  parameter int         NUM_REGS = 8,
  parameter logic [7:0] IO_BASE  = 8'h98,
  parameter int         IND_REG  = 17
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            io_addr,
  input  logic [7:0]            io_wdata,
  input  logic                  io_wr_stb,
  input  logic                  io_rd_stb,
  output logic [7:0]            io_rdata,
  output logic                  vram_req,
  output logic                  vram_we,
  output logic [ADDR_W-1:0]     vram_addr,
  output logic [7:0]            vram_wdata,
  input  logic                  vram_ack,
  input  logic [7:0]            vram_rdata,
  input  logic                  stat_f_set,
  input  logic                  stat_c_set,
  input  logic                  stat_5s_set,
  input  logic [4:0]            stat_5s_num,
  output logic [8*NUM_REGS-1:0] regs_flat,
  output logic                  n_int,
  output logic                  busy,
  output logic                  overrun
);

`ifdef VDP_INDIRECT_EN
  localparam logic IND_EN = 1'b1;
`else
  localparam logic IND_EN = 1'b0;
`endif

  logic [7:0]        regs [NUM_REGS];
  logic [ADDR_W-1:0] addr;
  logic [7:0]        rdbuf;
  logic [7:0]        first_byte;
  logic              toggle;
  logic [7:0]        status;

`ifdef VDP_INDIRECT_EN
  logic [5:0]        ptr;
  logic              noinc;
`endif

  // Decode and per-cycle actions
  port_e             port_sel;
  logic              data_wr;
  logic              data_rd;
  logic              ctrl_wr;
  logic              stat_rd;
  logic              ind_wr;
  logic              data_acc;
  logic              ctrl_prefetch;
  logic [ADDR_W-1:0] ctrl_addr;

  always_comb begin
    port_sel      = decode_port(io_addr, IO_BASE, IND_EN);
    // A read strobe coinciding with a write strobe is discarded.
    data_wr       = io_wr_stb && (port_sel == PORT_DATA);
    data_rd       = io_rd_stb && !io_wr_stb && (port_sel == PORT_DATA);
    ctrl_wr       = io_wr_stb && (port_sel == PORT_CTRL);
    stat_rd       = io_rd_stb && !io_wr_stb && (port_sel == PORT_CTRL);
    ind_wr        = io_wr_stb && (port_sel == PORT_IND);
    data_acc      = data_wr || data_rd;
    // Second control byte with bit7=0 loads the address; bit6=0 means
    // read setup, which also primes the read-ahead buffer.
    ctrl_prefetch = ctrl_wr && toggle && !io_wdata[7] && !io_wdata[6];
    ctrl_addr     = ADDR_W'({io_wdata[5:0], first_byte});
  end

  always_comb begin
    io_rdata = 8'hFF;
    case (port_sel)
      PORT_DATA: io_rdata = rdbuf;
      PORT_CTRL: io_rdata = status;
      default:   io_rdata = 8'hFF;
    endcase
  end

  // NOTE: the register file is a handful of flops, not a RAM macro, so it is
  // reset along with everything else and starts from a known all-zero state.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
      addr       <= '0;
      rdbuf      <= 8'h00;
      first_byte <= 8'h00;
      toggle     <= 1'b0;
      vram_req   <= 1'b0;
      vram_we    <= 1'b0;
      vram_addr  <= '0;
      vram_wdata <= 8'h00;
      overrun    <= 1'b0;
`ifdef VDP_INDIRECT_EN
      ptr        <= '0;
      noinc      <= 1'b0;
`endif
    end else begin
      // Completion of the outstanding access.
      if (vram_req && vram_ack) begin
        vram_req <= 1'b0;
        if (!vram_we) rdbuf <= vram_rdata;
      end

      // Control port writes are never blocked by a pending VRAM access.
      if (ctrl_wr) begin
        if (!toggle) begin
          first_byte <= io_wdata;
          toggle     <= 1'b1;
        end else begin
          toggle <= 1'b0;
          if (io_wdata[7]) begin
            for (int i = 0; i < NUM_REGS; i++)
              if (int'(io_wdata[5:0]) == i) regs[i] <= first_byte;
`ifdef VDP_INDIRECT_EN
            if (io_wdata[5:0] == 6'(IND_REG)) begin
              ptr   <= first_byte[5:0];
              noinc <= first_byte[7];
            end
`endif
          end else if (ctrl_prefetch && !vram_req) begin
            vram_req  <= 1'b1;
            vram_we   <= 1'b0;
            vram_addr <= ctrl_addr;
            addr      <= ctrl_addr + ADDR_W'(1);
          end else begin
            // Write setup, or a read setup whose prefetch could not be
            // issued because an access is still outstanding.
            addr <= ctrl_addr;
          end
        end
      end

      if (stat_rd) toggle <= 1'b0;

      // Data port: one access in flight at a time; extras are dropped.
      if (data_acc) begin
        toggle <= 1'b0;
        if (vram_req) begin
          overrun <= 1'b1;
        end else begin
          vram_req  <= 1'b1;
          vram_we   <= data_wr;
          vram_addr <= addr;
          addr      <= addr + ADDR_W'(1);
          if (data_wr) begin
            rdbuf      <= io_wdata;
            vram_wdata <= io_wdata;
          end
        end
      end

`ifdef VDP_INDIRECT_EN
      if (ind_wr) begin
        for (int i = 0; i < NUM_REGS; i++)
          if (int'(ptr) == i) regs[i] <= io_wdata;
        if (!noinc) ptr <= ptr + 6'd1;
      end
`endif
    end
  end

  always_comb begin
    regs_flat = '0;
    for (int i = 0; i < NUM_REGS; i++) regs_flat[8*i +: 8] = regs[i];
  end

  assign busy = vram_req;

  vdp_status_reg u_status (
    .clk    (clk),
    .reset  (reset),
    .f_set  (stat_f_set),
    .c_set  (stat_c_set),
    .s5_set (stat_5s_set),
    .s5_num (stat_5s_num),
    .rd_clr (stat_rd),
    .ie     (regs[1][R1_IE_BIT]),
    .status (status),
    .n_int  (n_int)
  );

endmodule

// File: tb/tb_vdp_cpu_port.sv
// ----------------------------------------------------------------------------
// tb_vdp_cpu_port
//   Self-checking bench for vdp_cpu_port (default parameters). Expected VRAM
//   requests are queued when the CPU stimulus is driven and popped when the
//   DUT raises vram_req. Builds with or without VDP_INDIRECT_EN.
// ----------------------------------------------------------------------------
module tb_vdp_cpu_port;

  localparam logic [7:0] P_DATA = 8'h98;
  localparam logic [7:0] P_CTRL = 8'h99;
  localparam logic [7:0] P_IND  = 8'h9B;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  io_addr;
  logic [7:0]  io_wdata;
  logic        io_wr_stb;
  logic        io_rd_stb;
  logic [7:0]  io_rdata;
  logic        vram_req;
  logic        vram_we;
  logic [13:0] vram_addr;
  logic [7:0]  vram_wdata;
  logic        vram_ack;
  logic [7:0]  vram_rdata;
  logic        stat_f_set;
  logic        stat_c_set;
  logic        stat_5s_set;
  logic [4:0]  stat_5s_num;
  logic [63:0] regs_flat;
  logic        n_int;
  logic        busy;
  logic        overrun;

  typedef struct {
    logic        we;
    logic [13:0] addr;
    logic [7:0]  wdata;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] exp_regs [8];
  int         compared   = 0;
  int         mismatched = 0;

  always #5 clk = ~clk;

  vdp_cpu_port dut (
    .clk         (clk),
    .reset       (reset),
    .io_addr     (io_addr),
    .io_wdata    (io_wdata),
    .io_wr_stb   (io_wr_stb),
    .io_rd_stb   (io_rd_stb),
    .io_rdata    (io_rdata),
    .vram_req    (vram_req),
    .vram_we     (vram_we),
    .vram_addr   (vram_addr),
    .vram_wdata  (vram_wdata),
    .vram_ack    (vram_ack),
    .vram_rdata  (vram_rdata),
    .stat_f_set  (stat_f_set),
    .stat_c_set  (stat_c_set),
    .stat_5s_set (stat_5s_set),
    .stat_5s_num (stat_5s_num),
    .regs_flat   (regs_flat),
    .n_int       (n_int),
    .busy        (busy),
    .overrun     (overrun)
  );

  function automatic logic [63:0] model_flat();
    logic [63:0] f;
    for (int i = 0; i < 8; i++) f[8*i +: 8] = exp_regs[i];
    return f;
  endfunction

  task automatic io_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    io_addr = a; io_wdata = d; io_wr_stb = 1'b1;
    @(negedge clk);
    io_wr_stb = 1'b0;
  endtask

  task automatic io_read(input logic [7:0] a, output logic [7:0] d);
    @(negedge clk);
    io_addr = a; io_rd_stb = 1'b1;
    #1 d = io_rdata;
    @(negedge clk);
    io_rd_stb = 1'b0;
  endtask

  task automatic ctrl_pair(input logic [7:0] b0, input logic [7:0] b1);
    io_write(P_CTRL, b0);
    io_write(P_CTRL, b1);
  endtask

  // Scoreboard consumer: wait for a request, match it against the oldest
  // expected entry, then acknowledge after 'lat' idle cycles.
  task automatic serve_vram(input logic [7:0] rd, input int lat);
    exp_t e;
    int   n = 0;
    while (!vram_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    compared++;
    if (!vram_req) begin
      mismatched++;
      $display("FAIL vram_req_timeout: got no request, required one (queue %0d)", sb.size());
      return;
    end
    if (sb.size() == 0) begin
      mismatched++;
      $display("FAIL vram_unexpected: got req we=%0b addr=%h, required none", vram_we, vram_addr);
    end else begin
      e = sb.pop_front();
      if (vram_we !== e.we || vram_addr !== e.addr || (e.we && vram_wdata !== e.wdata)) begin
        mismatched++;
        $display("FAIL vram_req: got we=%0b addr=%h wdata=%h, required we=%0b addr=%h wdata=%h",
                 vram_we, vram_addr, vram_wdata, e.we, e.addr, e.wdata);
      end
    end
    repeat (lat) @(negedge clk);
    compared++;
    if (busy !== 1'b1) begin
      mismatched++;
      $display("FAIL busy_pending: got %b, required 1", busy);
    end
    vram_ack = 1'b1; vram_rdata = rd;
    @(negedge clk);
    vram_ack = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) exp_regs[i] = 8'h00;
    sb.delete();
  endtask

  task automatic test_reset();
    logic [7:0] v;
    do_reset();
    compared++;
    if (regs_flat !== 64'h0) begin
      mismatched++; $display("FAIL reset_regs: got %h, required 0", regs_flat);
    end
    compared++;
    if (n_int !== 1'b1 || vram_req !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_outputs: got n_int=%b req=%b busy=%b ovr=%b, required 1 0 0 0",
               n_int, vram_req, busy, overrun);
    end
    io_read(P_CTRL, v);
    compared++;
    if (v !== 8'h00) begin
      mismatched++; $display("FAIL reset_status: got %h, required 00", v);
    end
  endtask

  task automatic test_write_addr();
    logic [7:0] v;
    ctrl_pair(8'h34, 8'h52);
    compared++;
    if (vram_req !== 1'b0) begin
      mismatched++; $display("FAIL write_setup_no_req: got %b, required 0", vram_req);
    end
    sb.push_back('{1'b1, 14'h1234, 8'hAA});
    io_write(P_DATA, 8'hAA);
    serve_vram(8'h00, 2);
    sb.push_back('{1'b1, 14'h1235, 8'h55});
    io_write(P_DATA, 8'h55);
    serve_vram(8'h00, 0);
    // The read-ahead buffer holds the last byte written.
    sb.push_back('{1'b0, 14'h1236, 8'h00});
    io_read(P_DATA, v);
    compared++;
    if (v !== 8'h55) begin
      mismatched++; $display("FAIL rdbuf_after_write: got %h, required 55", v);
    end
    serve_vram(8'h3C, 1);
  endtask

  task automatic test_read_prefetch();
    logic [7:0] v;
    sb.push_back('{1'b0, 14'h0100, 8'h00});
    ctrl_pair(8'h00, 8'h01);
    serve_vram(8'h5C, 1);
    sb.push_back('{1'b0, 14'h0101, 8'h00});
    io_read(P_DATA, v);
    compared++;
    if (v !== 8'h5C) begin
      mismatched++; $display("FAIL data_read_1: got %h, required 5C", v);
    end
    serve_vram(8'h77, 3);
    sb.push_back('{1'b0, 14'h0102, 8'h00});
    io_read(P_DATA, v);
    compared++;
    if (v !== 8'h77) begin
      mismatched++; $display("FAIL data_read_2: got %h, required 77", v);
    end
    serve_vram(8'h00, 0);
  endtask

  task automatic test_regs_int();
    logic [7:0] v;
    ctrl_pair(8'hE0, 8'h81);
    exp_regs[1] = 8'hE0;
    // Index 8 is beyond the register file and must be ignored.
    ctrl_pair(8'h5A, 8'h88);
    compared++;
    if (regs_flat !== model_flat()) begin
      mismatched++; $display("FAIL reg_write: got %h, required %h", regs_flat, model_flat());
    end
    @(negedge clk); stat_f_set = 1'b1;
    @(negedge clk); stat_f_set = 1'b0;
    compared++;
    if (n_int !== 1'b1) begin
      mismatched++; $display("FAIL n_int_latency: got %b, required 1", n_int);
    end
    @(negedge clk);
    compared++;
    if (n_int !== 1'b0) begin
      mismatched++; $display("FAIL n_int_assert: got %b, required 0", n_int);
    end
    io_read(P_CTRL, v);
    compared++;
    if (v !== 8'h80) begin
      mismatched++; $display("FAIL status_f: got %h, required 80", v);
    end
    @(negedge clk);
    compared++;
    if (n_int !== 1'b1) begin
      mismatched++; $display("FAIL n_int_release: got %b, required 1", n_int);
    end
    io_read(P_CTRL, v);
    compared++;
    if (v !== 8'h00) begin
      mismatched++; $display("FAIL status_cleared: got %h, required 00", v);
    end
  endtask

  task automatic test_status_flags();
    logic [7:0] v;
    // Set pulse coinciding with a status read: flag survives the clear.
    @(negedge clk);
    io_addr = P_CTRL; io_rd_stb = 1'b1; stat_c_set = 1'b1;
    #1 v = io_rdata;
    @(negedge clk);
    io_rd_stb = 1'b0; stat_c_set = 1'b0;
    compared++;
    if (v !== 8'h00) begin
      mismatched++; $display("FAIL status_set_win_read: got %h, required 00", v);
    end
    io_read(P_CTRL, v);
    compared++;
    if (v !== 8'h20) begin
      mismatched++; $display("FAIL status_c_kept: got %h, required 20", v);
    end
    @(negedge clk); stat_5s_set = 1'b1; stat_5s_num = 5'h13;
    @(negedge clk); stat_5s_set = 1'b0; stat_5s_num = 5'h00;
    io_read(P_CTRL, v);
    compared++;
    if (v !== 8'h53) begin
      mismatched++; $display("FAIL status_5s: got %h, required 53", v);
    end
    // Simultaneous rd+wr on the control port: only the write happens, so F
    // survives and the byte is taken as the first half of a pair.
    @(negedge clk); stat_f_set = 1'b1;
    @(negedge clk); stat_f_set = 1'b0;
    @(negedge clk);
    io_addr = P_CTRL; io_wdata = 8'h99; io_wr_stb = 1'b1; io_rd_stb = 1'b1;
    @(negedge clk);
    io_wr_stb = 1'b0; io_rd_stb = 1'b0;
    io_write(P_CTRL, 8'h82);
    exp_regs[2] = 8'h99;
    io_read(P_CTRL, v);
    compared++;
    if (v !== 8'h93) begin
      mismatched++; $display("FAIL status_rdwr_collide: got %h, required 93", v);
    end
    // Status read resets the byte latch: the dangling 8'h12 is forgotten.
    io_write(P_CTRL, 8'h12);
    io_read(P_CTRL, v);
    ctrl_pair(8'h66, 8'h83);
    exp_regs[3] = 8'h66;
    compared++;
    if (regs_flat !== model_flat()) begin
      mismatched++; $display("FAIL toggle_reset: got %h, required %h", regs_flat, model_flat());
    end
  endtask

  task automatic test_wrap_overrun();
    compared++;
    if (overrun !== 1'b0) begin
      mismatched++; $display("FAIL overrun_clean: got %b, required 0", overrun);
    end
    ctrl_pair(8'hFF, 8'h7F);
    sb.push_back('{1'b1, 14'h3FFF, 8'h01});
    io_write(P_DATA, 8'h01);
    io_write(P_DATA, 8'h02);
    compared++;
    if (overrun !== 1'b1 || busy !== 1'b1) begin
      mismatched++; $display("FAIL overrun_set: got ovr=%b busy=%b, required 1 1", overrun, busy);
    end
    serve_vram(8'h00, 1);
    sb.push_back('{1'b1, 14'h0000, 8'h03});
    io_write(P_DATA, 8'h03);
    serve_vram(8'h00, 0);
    compared++;
    if (overrun !== 1'b1 || sb.size() != 0) begin
      mismatched++; $display("FAIL overrun_sticky: got ovr=%b queue=%0d, required 1 0", overrun, sb.size());
    end
  endtask

  task automatic test_unmapped_indirect();
    logic [7:0] v;
    io_read(8'h10, v);
    compared++;
    if (v !== 8'hFF) begin
      mismatched++; $display("FAIL unmapped_read: got %h, required FF", v);
    end
    io_write(8'h10, 8'h5A);
    ctrl_pair(8'h02, 8'h91);
    io_write(P_IND, 8'h11);
    io_write(P_IND, 8'h22);
`ifdef VDP_INDIRECT_EN
    exp_regs[2] = 8'h11;
    exp_regs[3] = 8'h22;
`endif
    compared++;
    if (regs_flat !== model_flat() || vram_req !== 1'b0) begin
      mismatched++;
      $display("FAIL indirect_regs: got %h req=%b, required %h req=0", regs_flat, vram_req, model_flat());
    end
    io_read(P_IND, v);
    compared++;
    if (v !== 8'hFF) begin
      mismatched++; $display("FAIL indirect_read: got %h, required FF", v);
    end
  endtask

  task automatic test_reset_abandon();
    ctrl_pair(8'h00, 8'h40);
    io_write(P_DATA, 8'hC3);
    compared++;
    if (vram_req !== 1'b1) begin
      mismatched++; $display("FAIL abandon_issue: got %b, required 1", vram_req);
    end
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 8; i++) exp_regs[i] = 8'h00;
    compared++;
    if (vram_req !== 1'b0 || overrun !== 1'b0 || regs_flat !== 64'h0 || n_int !== 1'b1) begin
      mismatched++;
      $display("FAIL abandon_reset: got req=%b ovr=%b regs=%h n_int=%b, required 0 0 0 1",
               vram_req, overrun, regs_flat, n_int);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    io_addr = 8'h00; io_wdata = 8'h00; io_wr_stb = 1'b0; io_rd_stb = 1'b0;
    vram_ack = 1'b0; vram_rdata = 8'h00;
    stat_f_set = 1'b0; stat_c_set = 1'b0; stat_5s_set = 1'b0; stat_5s_num = 5'h00;
    test_reset();
    test_write_addr();
    test_read_prefetch();
    test_regs_int();
    test_status_flags();
    test_wrap_overrun();
    test_unmapped_indirect();
    test_reset_abandon();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
